// File: rtl/uart_tx_frame.sv
// UART transmitter with configurable data bits, parity and stop bits, valid/ready input.
// Optional line break generation via `UART_TX_FRAME_BREAK_EN (adds brk input).
module uart_tx_frame #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef UART_TX_FRAME_BREAK_EN
  input  logic                 brk,
`endif
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 busy,
  output logic                 tx_done,
  output logic                 txd
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST_BAUD = CW'(BAUD_DIV - 1);
  localparam bit HAS_PAR = (PARITY == 1) || (PARITY == 2);
  localparam logic PAR_ODD = (PARITY == 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = (STOP_BITS == 2) ? 4'd1 : 4'd0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_BRK   = 3'd5;

  logic [2:0]           state;
  logic [CW-1:0]        baud_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 par_next;
  logic                 tick;
  logic                 accept;
  logic                 brk_tail;
  logic                 brk_in;

`ifdef UART_TX_FRAME_BREAK_EN
  assign brk_in = brk;
`else
  assign brk_in = 1'b0;
`endif

  assign s_ready  = (state == S_IDLE);
  assign busy     = ~s_ready;
  assign tick     = (baud_cnt == LAST_BAUD);
  assign accept   = s_valid & s_ready & ~brk_in;
  // reduction XOR is 1 for an odd count of ones
  assign par_next = (^s_data) ^ PAR_ODD;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      brk_tail <= 1'b0;
      txd      <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state != S_IDLE)
        baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (brk_in) begin
            state    <= S_BRK;
            txd      <= 1'b0;
            baud_cnt <= '0;
            brk_tail <= 1'b0;
          end else if (accept) begin
            state    <= S_START;
            shreg    <= s_data;
            par_bit  <= par_next;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            txd      <= 1'b0;
          end
        end
        S_START: begin
          if (tick) begin
            state <= S_DATA;
            txd   <= shreg[0];
            shreg <= shreg >> 1;
          end
        end
        S_DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              if (HAS_PAR) begin
                state <= S_PAR;
                txd   <= par_bit;
              end else begin
                state <= S_STOP;
                txd   <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              txd     <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        S_PAR: begin
          if (tick) begin
            state <= S_STOP;
            txd   <= 1'b1;
          end
        end
        S_STOP: begin
          if (tick) begin
            if (bit_cnt == LAST_STOP) begin
              state   <= S_IDLE;
              tx_done <= 1'b1;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        S_BRK: begin
          // hold low while brk is high, then one full high bit period
          if (!brk_tail) begin
            baud_cnt <= '0;
            if (!brk_in) begin
              brk_tail <= 1'b1;
              txd      <= 1'b1;
            end
          end else if (tick) begin
            state    <= S_IDLE;
            brk_tail <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: 8N1, 7E2 and 8O1 instances at BAUD_DIV = 10.
// Break sequence is exercised only when UART_TX_FRAME_BREAK_EN is defined.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst;
  logic       brk;
  logic [8:0] sd [3];
  logic [2:0] sv;
  logic [2:0] rdy;
  logic [2:0] bsy;
  logic [2:0] done;
  logic [2:0] txd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(
    .CLK_FREQ(50_000_000), .BAUD(5_000_000),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) u0 (
    .clk(clk), .rst(rst),
`ifdef UART_TX_FRAME_BREAK_EN
    .brk(brk),
`endif
    .s_data(sd[0][7:0]), .s_valid(sv[0]), .s_ready(rdy[0]),
    .busy(bsy[0]), .tx_done(done[0]), .txd(txd[0])
  );

  uart_tx_frame #(
    .CLK_FREQ(50_000_000), .BAUD(5_000_000),
    .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
  ) u1 (
    .clk(clk), .rst(rst),
`ifdef UART_TX_FRAME_BREAK_EN
    .brk(1'b0),
`endif
    .s_data(sd[1][6:0]), .s_valid(sv[1]), .s_ready(rdy[1]),
    .busy(bsy[1]), .tx_done(done[1]), .txd(txd[1])
  );

  uart_tx_frame #(
    .CLK_FREQ(50_000_000), .BAUD(5_000_000),
    .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)
  ) u2 (
    .clk(clk), .rst(rst),
`ifdef UART_TX_FRAME_BREAK_EN
    .brk(1'b0),
`endif
    .s_data(sd[2][7:0]), .s_valid(sv[2]), .s_ready(rdy[2]),
    .busy(bsy[2]), .tx_done(done[2]), .txd(txd[2])
  );

  typedef struct {
    int         d;
    logic [8:0] data;
    string      bits;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, expv);
    end
  endtask

  // starts at #1 after an edge with DUT d idle; ends #1 after edge F
  task automatic frame(input int d, input logic [8:0] data, input string bits,
                       input bit keep, input logic [8:0] nd);
    int f;
    f = bits.len() * 10;
    check($sformatf("d%0d ready_pre %h", d, data), rdy[d], 1'b1);
    sd[d] = data;
    sv[d] = 1'b1;
    @(posedge clk); #1;
    if (!keep) sv[d] = 1'b0;
    for (int k = 0; k < f; k++) begin
      if (k == 30) sd[d] = nd;
      check($sformatf("d%0d %h txd k%0d", d, data, k), txd[d],
            bits.getc(k / 10) == 8'h31);
      check($sformatf("d%0d %h done k%0d", d, data, k), done[d], 1'b0);
      check($sformatf("d%0d %h ready k%0d", d, data, k), rdy[d], 1'b0);
      check($sformatf("d%0d %h busy k%0d", d, data, k), bsy[d], 1'b1);
      if (k < f - 1) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    check($sformatf("d%0d %h done_end", d, data), done[d], 1'b1);
    check($sformatf("d%0d %h ready_end", d, data), rdy[d], 1'b1);
    check($sformatf("d%0d %h txd_end", d, data), txd[d], 1'b1);
  endtask

  initial begin
    vecs[0] = '{0, 9'h0A5, "0101001011"};
    vecs[1] = '{1, 9'h035, "01010110011"};
    vecs[2] = '{2, 9'h000, "00000000011"};
    vecs[3] = '{2, 9'h0FF, "01111111111"};
    vecs[4] = '{0, 9'h03C, "0001111001"};
    vecs[5] = '{1, 9'h07F, "01111111111"};

    rst = 1'b1;
    brk = 1'b0;
    sv  = '0;
    for (int i = 0; i < 3; i++) sd[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst d%0d txd", i), txd[i], 1'b1);
      check($sformatf("rst d%0d done", i), done[i], 1'b0);
      check($sformatf("rst d%0d ready", i), rdy[i], 1'b1);
      check($sformatf("rst d%0d busy", i), bsy[i], 1'b0);
    end

    for (int i = 0; i < 6; i++)
      frame(vecs[i].d, vecs[i].data, vecs[i].bits, 1'b0, ~vecs[i].data);

    // back-to-back with s_valid held and s_data changed mid-frame
    frame(0, 9'h011, "0100010001", 1'b1, 9'h022);
    frame(0, 9'h022, "0010001001", 1'b0, 9'h000);
    @(posedge clk); #1;
    check("b2b idle txd", txd[0], 1'b1);
    check("b2b idle ready", rdy[0], 1'b1);

    // reset in the middle of a frame
    sd[0] = 9'h0A5;
    sv[0] = 1'b1;
    @(posedge clk); #1;
    sv[0] = 1'b0;
    repeat (45) @(posedge clk);
    #1;
    check("mid rst busy_pre", bsy[0], 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid rst txd", txd[0], 1'b1);
    check("mid rst done", done[0], 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid rst ready", rdy[0], 1'b1);
    check("mid rst busy", bsy[0], 1'b0);
    check("mid rst txd2", txd[0], 1'b1);
    frame(0, 9'h05A, "0010110101", 1'b0, 9'h000);

`ifdef UART_TX_FRAME_BREAK_EN
    begin
      string bits;
      logic et, ed, er;
      bits = "0101001011";
      @(posedge clk); #1;
      sd[0] = 9'h0A5;
      sv[0] = 1'b1;
      @(posedge clk); #1;
      sv[0] = 1'b0;
      for (int k = 0; k <= 141; k++) begin
        et = 1'b1; ed = 1'b0; er = 1'b0;
        if (k < 100) et = (bits.getc(k / 10) == 8'h31);
        else if (k == 100) begin ed = 1'b1; er = 1'b1; end
        else if (k <= 130) et = 1'b0;
        else if (k == 141) er = 1'b1;
        check($sformatf("brk txd k%0d", k), txd[0], et);
        check($sformatf("brk done k%0d", k), done[0], ed);
        check($sformatf("brk ready k%0d", k), rdy[0], er);
        if (k == 80) brk = 1'b1;
        if (k == 130) brk = 1'b0;
        @(posedge clk); #1;
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter: successor to the fixed 8N1 transmitter, with configurable data width, parity and stop bits, plus a valid/ready input handshake. It sits between a byte or word producer (command engine, FIFO read side) and the board TX pin. It serialises one frame per accepted word, LSB first, and reports frame completion.

## Interface
- `CLK_FREQ`, default 50_000_000: clock frequency in Hz.
- `BAUD`, default 115_200: line rate in bit/s.
- `DATA_BITS`, default 8: data bits per frame, legal range 5..9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even; any other value behaves as none.
- `STOP_BITS`, default 1: 1 or 2; any other value behaves as 1.
- `clk` input 1: the only clock; all logic is on its rising edge.
- `rst` input 1: synchronous reset, active-high.
- `s_data` input DATA_BITS: word to send. Sampled only on the handshake edge.
- `s_valid` input 1: producer has a word.
- `s_ready` output 1: block can accept a word.
- `busy` output 1: a frame (or break, see Configuration) is in progress.
- `tx_done` output 1: one-cycle pulse at the end of each frame.
- `txd` output 1: serial line, idle high.

## Operation
- `BAUD_DIV = CLK_FREQ / BAUD`, with integer truncation; it must be ≥ 2. The baud counter width is `$clog2(BAUD_DIV)`; the counter counts 0..BAUD_DIV-1 and wraps.
- State machine states: IDLE, START, DATA, PAR, STOP.
  - IDLE → START on the handshake (`s_valid & s_ready`).
  - START → DATA after 1 bit period.
  - DATA → PAR (if PARITY ≠ 0) or STOP after DATA_BITS bit periods.
  - PAR → STOP after 1 bit period.
  - STOP → IDLE after STOP_BITS bit periods.
- `s_ready` = (state == IDLE); it is a combinational decode of the registered state. `busy` = !s_ready.
- On the handshake edge: `s_data` is latched into a shift register, the parity bit is computed, the baud counter and bit counter are cleared, and `txd` is set to 0.
- `s_data` changes after acceptance have no effect on the current frame.
- Data is sent LSB first, one bit per BAUD_DIV cycles.
- Parity is computed over all DATA_BITS latched bits:
  - Even: the parity bit makes the count of 1s across data + parity even.
  - Odd: the parity bit makes that count odd.
- Stop bits drive `txd` = 1.
- `s_valid` while busy is ignored: no queueing and no loss of the pending word, because `s_ready` is low.
- Reset mid-frame: the frame is abandoned. The next edge after `rst` deasserts is treated as IDLE.
- Reset values: `txd` = 1, `tx_done` = 0, state IDLE (so `s_ready` = 1 and `busy` = 0 once reset is released), all counters 0.

## Timing
- `txd` is registered. The start bit appears on the edge of the handshake; latency is 0 cycles after that edge.
- Frame length: `F = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × BAUD_DIV` cycles, measured from the handshake edge.
- Edge F after the handshake sets all of the following together:
  - state becomes IDLE;
  - `tx_done` = 1 for exactly one cycle;
  - `s_ready` = 1.
- Back-to-back frames: if `s_valid` is high in the cycle `s_ready` returns, the next start bit begins at edge F+1. The gap is 1 idle cycle; `txd` stays high for it.
- `tx_done` and a new handshake may coincide in the same cycle.

## Configuration
- `UART_TX_FRAME_BREAK_EN` defined: adds input `brk` (1 bit) and one extra state, BRK.
  - `brk` high in IDLE → state BRK on the next edge; `txd` = 0, `s_ready` = 0, `busy` = 1.
  - `brk` asserted mid-frame: the current frame completes normally (including `tx_done`), then BRK is entered.
  - On `brk` fall, `txd` = 1 is held for one full bit period (BAUD_DIV cycles) before returning to IDLE.
  - No `tx_done` pulse is generated for a break.
  - A handshake is ignored while `brk` is high, even in IDLE.
- Macro undefined: no `brk` port and no BRK state; behaviour is exactly as above.

## Test plan
All scenarios use CLK_FREQ = 50_000_000 and BAUD = 5_000_000, so BAUD_DIV = 10.
- 8N1, send 0xA5 → `txd` reads 0,1,0,1,0,0,1,0,1,1, each bit held 10 cycles. `tx_done` pulses 100 cycles after the handshake.
- DATA_BITS = 7, PARITY = 2, STOP_BITS = 2, send 0x35 → bits 0,1,0,1,0,1,1,0,0,1,1. Parity is 0 (four 1s). `tx_done` at cycle 110.
- PARITY = 1, send 0x00 → parity bit = 1. Then send 0xFF → parity bit = 1.
- `s_valid` held high with data 0x11 then 0x22, changing `s_data` mid-frame:
  - two frames are sent, 0x11 then 0x22, separated by exactly 1 high cycle;
  - the mid-frame `s_data` change does not alter the first frame.
- `rst` pulsed at cycle 45 of a frame:
  - `txd` = 1 and `tx_done` = 0 on the following edge;
  - `s_ready` = 1 after release;
  - a new 0x5A frame then transmits correctly.
- With `UART_TX_FRAME_BREAK_EN`, `brk` raised mid-frame for 50 cycles:
  - the frame completes and `tx_done` pulses;
  - `txd` then stays low until `brk` falls, followed by 10 high cycles;
  - `s_ready` rises only after those 10 cycles.
